seq_mag_cmp: RTL
================

# seq_mag_cmp

Multi-cycle magnitude comparator for wide operands. It accepts a P/Q pair through a valid/ready handshake and walks the operands one CHUNK-bit slice per cycle, starting at the most-significant slice. It stops at the first unequal slice and returns the one-hot GT/EQ/LT result through a second valid/ready handshake. It is the sequential, MSB-first counterpart to the team's combinational LSB-first chained comparator, for datapaths that cannot afford a 64-bit compare in one cycle.

## Interface
- WIDTH, 64: operand width; must be an exact multiple of CHUNK.
- CHUNK, 8: bits compared per cycle.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair P/Q is valid.
- in_ready  out  1  block can accept an operand pair.
- is_signed  in  1  treat operands as two's complement; sampled together with P/Q.
- P  in  WIDTH  first operand.
- Q  in  WIDTH  second operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- OPGTQ  out  1  P > Q.
- OPEQQ  out  1  P == Q.
- OPLTQ  out  1  P < Q.
- chunks_used  out  $clog2(WIDTH/CHUNK)+1  number of slices examined for the current result (1..NCHUNK).

## Operation
- NCHUNK = WIDTH/CHUNK. Slice i is bits [i*CHUNK+CHUNK-1 : i*CHUNK].
- The state machine has three states.
- **IDLE**
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready, latch P, Q and is_signed, set idx=NCHUNK-1, set chunks_used=0, and go to CMP.
- **CMP**
  - in_ready=0. Compare slice idx unsigned.
  - When idx==NCHUNK-1 and the latched is_signed=1, invert the MSB of both slices before the compare.
  - Increment chunks_used every CMP cycle.
  - If the slices differ, load the GT or LT result and go to DONE.
  - Else if idx==0, load the EQ result and go to DONE.
  - Else decrement idx and stay in CMP.
- **DONE**
  - out_valid=1 and in_ready=0.
  - OPGTQ/OPEQQ/OPLTQ and chunks_used are held stable.
  - On out_ready, go to IDLE.
- Result flags are exactly one-hot whenever out_valid=1.
- P/Q changes while the block is not in IDLE are ignored; the latched copy is used.
- No new operand is accepted in the cycle a result is consumed. The next accept can happen no earlier than the following cycle, from IDLE.

## Timing
- **Reset**
  - While rst=1: state=IDLE, in_ready=0, out_valid=0, OPGTQ=0, OPEQQ=0, OPLTQ=0, chunks_used=0.
  - in_ready rises in the first cycle after rst deasserts.
  - rst in CMP or DONE aborts the operation; no result is produced.
- **Latency**
  - Accept at edge 0.
  - out_valid is high after edge k, where k = chunks_used (1..NCHUNK).
  - Best case (MSB slices differ): out_valid after edge 1.
  - Worst case (equal operands, or only slice 0 differs): out_valid after edge NCHUNK (8 for the defaults).
- **Backpressure**
  - With out_ready=0, DONE is held indefinitely with outputs stable.
  - If out_ready=1 already when DONE is entered, out_valid is high for exactly one cycle.
- **Throughput**
  - One result per k+2 cycles with out_ready tied high (CMP k cycles, DONE 1 cycle, IDLE 1 cycle).
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package cmp_pkg:
  - state enum {IDLE, CMP, DONE}.
  - NCHUNK and the chunks_used width as localparam functions of WIDTH/CHUNK.
  - a one-hot result encoding constant set: GT=3'b100, EQ=3'b010, LT=3'b001.
- Sub-module cmp_slice: combinational CHUNK-bit compare with an msb_invert input, giving gt/lt outputs. It is instantiated once and fed by an idx-driven mux.
- Top level holds the FSM, the operand registers, idx, chunks_used and the result register.

## Test plan
- Unsigned, MSB slice differs: P=64'h8000_0000_0000_0000, Q=64'h7FFF_FFFF_FFFF_FFFF, is_signed=0 -> OPGTQ=1, chunks_used=1, out_valid one cycle after accept.
- Equal operands: P=Q=64'hDEAD_BEEF_0123_4567 -> OPEQQ=1, chunks_used=8, out_valid after 8 cycles.
- Difference only in the LSB: P=64'h1, Q=64'h2 -> OPLTQ=1, chunks_used=8.
- Signed mode: P=64'hFFFF_FFFF_FFFF_FFFF (-1), Q=64'h1, is_signed=1 -> OPLTQ=1, chunks_used=1. The same operands with is_signed=0 -> OPGTQ=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout, and P/Q toggling during that time has no effect. Then out_ready=1 -> one transfer, and in_ready=1 on the next cycle.
- Reset mid-compare: assert rst in the 3rd CMP cycle of an equal-operand compare -> out_valid never rises, all outputs 0, and in_ready=1 one cycle after rst drops. A subsequent P=5, Q=3 gives OPGTQ=1 with chunks_used=8.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package cmp_pkg;

    // Controller states; exported on the debug port of the top level.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default geometry of the comparator.
    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 8;

    // One-hot result encoding, ordered {GT, EQ, LT}.
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the slice counter; must hold the value NCHUNK itself.
    function automatic int calc_cnt_w(input int width, input int chunk);
        return $clog2(width / chunk) + 1;
    endfunction

    // Width of the slice index; at least one bit even for a single slice.
    function automatic int calc_idx_w(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mag_cmp_if.sv
// Operand and result handshake bundle of the sequential magnitude comparator.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds its payload
// stable while valid is high and ready is low; valid never depends on ready.
interface seq_mag_cmp_if #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
);
    import cmp_pkg::*;

    localparam int CNT_W = calc_cnt_w(WIDTH, CHUNK);

    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic             OPGTQ;
    logic             OPEQQ;
    logic             OPLTQ;
    logic [CNT_W-1:0] chunks_used;

    // Side that supplies operands and consumes results.
    modport master (
        output in_valid,
        output is_signed,
        output P,
        output Q,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  OPGTQ,
        input  OPEQQ,
        input  OPLTQ,
        input  chunks_used
    );

    // The comparator itself.
    modport slave (
        input  in_valid,
        input  is_signed,
        input  P,
        input  Q,
        input  out_ready,
        output in_ready,
        output out_valid,
        output OPGTQ,
        output OPEQQ,
        output OPLTQ,
        output chunks_used
    );

endinterface

// File: rtl/cmp_slice.sv
// Combinational compare of one CHUNK-bit slice. With msb_invert_i set the
// slice MSB is flipped on both sides, which turns an unsigned compare of the
// top slice into a two's complement compare of the whole operand.
module cmp_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             msb_invert_i,
    output logic             gt_o,
    output logic             lt_o
);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    // Build the MSB flip mask and the adjusted slices.
    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = msb_invert_i;
        a_m             = a_i ^ flip;
        b_m             = b_i ^ flip;
    end

    // Plain unsigned compare of the adjusted slices.
    always_comb begin
        gt_o = (a_m > b_m);
        lt_o = (a_m < b_m);
    end

endmodule

// File: rtl/seq_mag_cmp.sv
// Sequential MSB-first magnitude comparator. Latches an operand pair, walks
// it one slice per cycle from the top and stops at the first unequal slice,
// then presents a one-hot GT/EQ/LT result until it is consumed.
// WIDTH must be an exact multiple of CHUNK.
module seq_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic          clk,
    input  logic          rst,
    seq_mag_cmp_if.slave  bus,
    output state_t        dbg_state_o
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = calc_cnt_w(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(WIDTH, CHUNK);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Controller and datapath registers
    state_t           state_q,  state_d;
    logic [WIDTH-1:0] p_q,      p_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       res_q,    res_d;
    logic             rdy_q,    rdy_d;

    // Slice selected by idx and its compare result
    logic [CHUNK-1:0] slice_p;
    logic [CHUNK-1:0] slice_q;
    logic             msb_invert;
    logic             slice_gt;
    logic             slice_lt;

    // Select the current slice; the sign fix-up only applies to the top slice.
    always_comb begin
        slice_p    = p_q[idx_q*CHUNK +: CHUNK];
        slice_q    = q_q[idx_q*CHUNK +: CHUNK];
        msb_invert = signed_q && (idx_q == LAST_IDX);
    end

    cmp_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i          (slice_p),
        .b_i          (slice_q),
        .msb_invert_i (msb_invert),
        .gt_o         (slice_gt),
        .lt_o         (slice_lt)
    );

    // Next-state and datapath update: accept in IDLE, scan in CMP, hold in DONE.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        q_d      = q_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        rdy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // rdy_q is low for the first cycle out of reset, so acceptance
                // is gated by it rather than by the state alone.
                if (bus.in_valid && rdy_q) begin
                    p_d      = bus.P;
                    q_d      = bus.Q;
                    signed_d = bus.is_signed;
                    idx_d    = LAST_IDX;
                    cnt_d    = '0;
                    res_d    = RES_NONE;
                    state_d  = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (slice_gt) begin
                    res_d   = RES_GT;
                    state_d = DONE;
                end else if (slice_lt) begin
                    res_d   = RES_LT;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered so it never depends combinationally on inputs.
        rdy_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            q_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            res_q    <= RES_NONE;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            q_q      <= q_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            rdy_q    <= rdy_d;
        end
    end

    // Outputs come straight from registers or from the state decode.
    always_comb begin
        bus.in_ready    = rdy_q;
        bus.out_valid   = (state_q == DONE);
        bus.OPGTQ       = res_q[2];
        bus.OPEQQ       = res_q[1];
        bus.OPLTQ       = res_q[0];
        bus.chunks_used = cnt_q;
        dbg_state_o     = state_q;
    end

endmodule
